// File: rtl/arb_mux_reg_if.sv
// Channel-side and consumer-side bundle for arb_mux_reg.
// The slave modport is the arbiter's view; master is the producer/consumer environment.
interface arb_mux_reg_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4
);
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/arb_mux_reg.sv
// N-channel arbitrating selector feeding one registered valid/ready output stage.
// Handshake: a transfer happens on any edge where valid && ready; the output register reloads whenever it is empty or being drained.
module arb_mux_reg #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int MODE  = 0
) (
    input logic clk,
    input logic rst_n,
    arb_mux_reg_if.slave bus
);
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [SELW-1:0]  last_q;
    logic [SELW-1:0]  win;
    logic [WIDTH-1:0] sel_data;
    logic [NCH-1:0]   grant;
    logic [WIDTH-1:0] data_q;
    logic [SELW-1:0]  ch_q;
    logic             valid_q;
    logic             load_en;
    logic             any_req;

    assign load_en = !valid_q || bus.out_ready;
    assign any_req = |bus.in_valid;

    // Scan in reverse preference order so the most preferred requester is written last.
    always_comb begin : pick
        int             idx;
        logic [NCH-1:0] vshift;
        win    = '0;
        idx    = 0;
        vshift = '0;
        if (MODE == 1) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                vshift = bus.in_valid >> i;
                if (vshift[0]) win = SELW'(i);
            end
        end else begin
            for (int k = NCH; k >= 1; k--) begin
                idx = int'(last_q) + k;
                if (idx >= NCH) idx = idx - NCH;
                vshift = bus.in_valid >> idx;
                if (vshift[0]) win = SELW'(idx);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (win == SELW'(i)) sel_data = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NCH; i++) begin
            grant[i] = load_en && any_req && (win == SELW'(i));
        end
    end

    // Grants are forced low while reset is held, independent of register state.
    assign bus.in_ready = grant & {NCH{rst_n}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            last_q  <= SELW'(NCH - 1);
        end else if (load_en) begin
            valid_q <= any_req;
            if (any_req) begin
                data_q <= sel_data;
                ch_q   <= win;
                if (MODE == 0) last_q <= win;
            end
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
    assign bus.out_valid = valid_q;
endmodule
